// File: rtl/switch_stage_feeder.sv
// Tile buffer feeding the transpose switch stage: loads N rows, then streams row k, column k and ctrl per beat.
// Latency: beat 0 is visible right after the last row is accepted; a stalled beat holds all outputs until out_ready.
module switch_stage_feeder #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int STRIDE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0][WIDTH-1:0]   in_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0][WIDTH-1:0]   out_down,
    output logic [N-1:0][WIDTH-1:0]   out_across,
    output logic                      ctrl,
    output logic                      out_last
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam int SW = $clog2(STRIDE);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  row_cnt_q, row_cnt_d;
    logic [CW-1:0]                  k_q, k_d;
    logic [N-1:0][N-1:0][WIDTH-1:0] tile_q;
    logic                           load_fire;
    logic [CW-1:0]                  k_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            row_cnt_q <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            k_q       <= k_d;
        end
    end

    // Tile storage is deliberately left out of reset; counters alone define validity.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            tile_q[row_cnt_q] <= in_row;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_fire = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_fire = 1'b1;
                    if (row_cnt_q == CNT_LAST) begin
                        row_cnt_d = '0;
                        k_d       = '0;
                        state_d   = ST_STREAM;
                    end else begin
                        row_cnt_d = row_cnt_q + CW'(1);
                    end
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (k_q == CNT_LAST) begin
                        k_d     = '0;
                        state_d = ST_LOAD;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Bit SW of k selects the ctrl phase, i.e. (k / STRIDE) & 1.
    assign k_phase = k_q >> SW;

    always_comb begin
        out_down   = '0;
        out_across = '0;
        ctrl       = 1'b1;
        out_last   = 1'b0;
        if (state_q == ST_STREAM) begin
            out_down = tile_q[k_q];
            for (int j = 0; j < N; j++) begin
                out_across[j] = tile_q[j][k_q];
            end
            ctrl     = ~k_phase[0];
            out_last = (k_q == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_switch_stage_feeder.sv
module tb_switch_stage_feeder;

    typedef logic [3:0][7:0] row_t;

    typedef struct packed {
        row_t down;
        row_t across;
        logic ctrl;
        logic last;
    } beat_t;

    typedef struct packed {
        logic in_ready;
        logic out_valid;
        row_t down;
        row_t across;
        logic ctrl;
        logic last;
    } obs_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_ready;
    row_t in_row;
    logic out_valid;
    logic out_ready;
    row_t out_down;
    row_t out_across;
    logic ctrl;
    logic out_last;

    int checks;
    int failures;

    row_t  rows_q[$];
    beat_t beats_q[$];

    obs_t  reset_obs;
    int    ctrl_seq[4];

    switch_stage_feeder #(.WIDTH(8), .N(4), .STRIDE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_down   (out_down),
        .out_across (out_across),
        .ctrl       (ctrl),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    function automatic row_t spec_row(input int i);
        row_t r;
        for (int j = 0; j < 4; j++) r[j] = 8'((i << 4) | j);
        return r;
    endfunction

    function automatic row_t fill_row(input logic [7:0] v);
        row_t r;
        for (int j = 0; j < 4; j++) r[j] = v;
        return r;
    endfunction

    // A complete tile turns into four expected beats: row k, column k, phase of k, last flag.
    task automatic build_beats();
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                b.down[j]   = rows_q[k][j];
                b.across[j] = rows_q[j][k];
            end
            b.ctrl = (((k / 2) % 2) == 0);
            b.last = (k == 3);
            beats_q.push_back(b);
        end
        rows_q.delete();
    endtask

    function automatic obs_t exp_obs();
        obs_t o;
        if (beats_q.size() == 0) begin
            o = reset_obs;
        end else begin
            o.in_ready  = 1'b0;
            o.out_valid = 1'b1;
            o.down      = beats_q[0].down;
            o.across    = beats_q[0].across;
            o.ctrl      = beats_q[0].ctrl;
            o.last      = beats_q[0].last;
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.in_ready  = in_ready;
        o.out_valid = out_valid;
        o.down      = out_down;
        o.across    = out_across;
        o.ctrl      = ctrl;
        o.last      = out_last;
        return o;
    endfunction

    task automatic cycle(input logic v, input row_t row, input logic r);
        in_valid  = v;
        in_row    = row;
        out_ready = r;
        @(posedge clk);
        if (beats_q.size() != 0) begin
            if (r) beats_q.delete(0);
        end else if (v) begin
            rows_q.push_back(row);
            if (rows_q.size() == 4) build_beats();
        end
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        rst       = 1'b1;
        rows_q.delete();
        beats_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        apply_reset();
        o = dut_obs();
        checks++;
        if (o !== reset_obs) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", o, reset_obs);
        end
        checks++;
        if (o !== exp_obs()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", o, exp_obs());
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, spec_row(i), 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_stream out_valid got=%b exp=1", out_valid);
        end
        #3 rst = 1'b1;
        #1;
        o = dut_obs();
        checks++;
        if (o !== reset_obs) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", o, reset_obs);
        end
        rows_q.delete();
        beats_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        obs_t o;
        row_t d1, a1;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, spec_row(i), 1'b1);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_enter_stream got=%b%b exp=01", in_ready, out_valid);
        end
        d1 = spec_row(1);
        for (int j = 0; j < 4; j++) a1[j] = 8'((j << 4) | 1);
        for (int k = 0; k < 4; k++) begin
            o = dut_obs();
            checks++;
            if (o !== exp_obs()) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h exp=%h", k, o, exp_obs());
            end
            checks++;
            if (ctrl !== 1'(ctrl_seq[k]) || out_last !== (k == 3)) begin
                failures++;
                $display("FAIL basic_ctrl_last%0d got=%b%b exp=%0d%0d", k, ctrl, out_last, ctrl_seq[k], (k == 3));
            end
            if (k == 1) begin
                checks++;
                if (out_down !== d1 || out_across !== a1) begin
                    failures++;
                    $display("FAIL basic_beat1_vectors got=%h/%h exp=%h/%h", out_down, out_across, d1, a1);
                end
            end
            cycle(1'b0, '0, 1'b1);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_back_to_load got=%b%b exp=10", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        row_t a2;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, spec_row(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int j = 0; j < 4; j++) a2[j] = 8'((j << 4) | 2);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b0);
            checks++;
            if (out_down !== spec_row(2) || out_across !== a2 || ctrl !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got=%h/%h/%b exp=%h/%h/0", c, out_down, out_across, ctrl, spec_row(2), a2);
            end
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (dut_obs() !== exp_obs() || out_last !== 1'b1 || out_down !== spec_row(3)) begin
            failures++;
            $display("FAIL bp_beat3 got=%h exp=%h", dut_obs(), exp_obs());
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_reload in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_input_gaps();
        row_t acr;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            cycle((c % 2) == 0, spec_row(c / 2), 1'b0);
            checks++;
            if (out_valid !== (c >= 6)) begin
                failures++;
                $display("FAIL gaps_valid_c%0d got=%b exp=%0d", c, out_valid, (c >= 6));
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) acr[j] = 8'((j << 4) | k);
            checks++;
            if (out_down !== spec_row(k) || out_across !== acr || dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL gaps_beat%0d got=%h/%h exp=%h/%h", k, out_down, out_across, spec_row(k), acr);
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_overflow();
        logic has_ff;
        apply_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, (c < 4) ? spec_row(c) : fill_row(8'hFF), 1'b0);
        checks++;
        if (in_ready !== 1'b0 || dut_obs() !== exp_obs()) begin
            failures++;
            $display("FAIL ovf_blocked got=%h exp=%h", dut_obs(), exp_obs());
        end
        for (int k = 0; k < 4; k++) begin
            has_ff = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (out_down[j] === 8'hFF || out_across[j] === 8'hFF) has_ff = 1'b1;
            end
            checks++;
            if (has_ff !== 1'b0 || dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL ovf_beat%0d got=%h exp=%h", k, dut_obs(), exp_obs());
            end
            cycle(1'b1, fill_row(8'hFF), 1'b1);
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_end got=%b%b exp=10", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, spec_row(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (out_down !== spec_row(1)) begin
            failures++;
            $display("FAIL rms_beat1 got=%h exp=%h", out_down, spec_row(1));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_obs() !== reset_obs) begin
            failures++;
            $display("FAIL rms_abort got=%h exp=%h", dut_obs(), reset_obs);
        end
        rows_q.delete();
        beats_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, fill_row(8'hAA), 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_down !== fill_row(8'hAA) || out_across !== fill_row(8'hAA) ||
                ctrl !== 1'(ctrl_seq[k]) || out_last !== (k == 3) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL rms_aa_beat%0d got=%h exp=%h", k, dut_obs(), exp_obs());
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_random();
        row_t r;
        int   bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < 4; j++) r[j] = 8'($urandom);
            cycle(($urandom % 4) != 0, r, ($urandom % 3) != 0);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                bad++;
                if (bad < 10) $display("FAIL random_c%0d got=%h exp=%h", c, dut_obs(), exp_obs());
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        checks    = 0;
        failures  = 0;
        reset_obs = '{in_ready: 1'b1, out_valid: 1'b0, down: '0, across: '0, ctrl: 1'b1, last: 1'b0};
        ctrl_seq  = '{1, 1, 0, 0};
        test_reset();
        test_basic();
        test_backpressure();
        test_input_gaps();
        test_overflow();
        test_reset_mid_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
